// File: rtl/dru_gearbox_lane.sv
// 4x-oversampled data recovery lane: phase tracking with edge filter, lock detect and
// an OUT_W-bit output gearbox. Optional bitslip support is built when DRU_BITSLIP_EN is defined.
module dru_gearbox_lane #(
    parameter int OUT_W      = 10,
    parameter int FILTER_LEN = 1,
    parameter int LOCK_CNT   = 64
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [7:0]       sample_window,
    input  logic             bitslip,
    output logic [OUT_W-1:0] rx_data,
    output logic             rx_valid,
    output logic [2:0]       raw_bits,
    output logic [1:0]       raw_nbits,
    output logic [1:0]       phase,
    output logic             locked
);
    localparam int                ACC_W      = OUT_W + 2;
    localparam int                CNT_W      = 6;
    localparam logic [3:0]        FILT_LEN_C = 4'(FILTER_LEN);
    localparam logic [15:0]       LOCK_MAX_C = 16'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  OUT_W_C    = CNT_W'(OUT_W);

    logic [7:0]       w_r;
    logic             prev7_r;
    logic             v1_r;
    logic [1:0]       phase_r;
    logic [3:0]       filt_cnt_r;
    logic             last_dir_r;
    logic [2:0]       raw_bits_r;
    logic [1:0]       raw_nbits_r;
    logic [15:0]      lock_cnt_r;
    logic             locked_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] gb_cnt_r;
    logic [OUT_W-1:0] rx_data_r;
    logic             rx_valid_r;

    logic [7:0]       edge_s;
    logic [3:0]       cls_s;
    logic [1:0]       p_up_s;
    logic [1:0]       p_dn_s;
    logic             later_s;
    logic             earlier_s;
    logic             move_s;
    logic [3:0]       filt_inc_s;
    logic [3:0]       filt_nxt_s;
    logic [1:0]       phase_nxt_s;
    logic [2:0]       raw_bits_s;
    logic [1:0]       raw_nbits_s;
    logic [2:0]       app_bits_s;
    logic [1:0]       app_n_s;
    logic [ACC_W-1:0] merged_s;
    logic [CNT_W-1:0] total_s;
    logic             emit_s;
    logic             slip_take_s;

    // Stage 1: register the window and remember the last sample of the previous one
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            w_r     <= 8'h00;
            prev7_r <= 1'b0;
            v1_r    <= 1'b0;
        end else begin
            w_r     <= sample_window;
            prev7_r <= w_r[7];
            v1_r    <= 1'b1;
        end
    end

    // Phase decision: edge classes, filtered move request and recovered bits
    always_comb begin
        edge_s     = w_r ^ {w_r[6:0], prev7_r};
        cls_s      = edge_s[3:0] | edge_s[7:4];
        p_up_s     = phase_r + 2'd1;
        p_dn_s     = phase_r - 2'd1;
        later_s    = cls_s[p_dn_s] | cls_s[phase_r];
        earlier_s  = cls_s[p_up_s];
        filt_inc_s = 4'd1;
        filt_nxt_s = 4'd0;
        move_s     = 1'b0;
        // Conflicting or absent requests clear the filter
        if (later_s ^ earlier_s) begin
            if ((filt_cnt_r != 4'd0) && (last_dir_r == later_s)) begin
                filt_inc_s = filt_cnt_r + 4'd1;
            end else begin
                filt_inc_s = 4'd1;
            end
            if (filt_inc_s >= FILT_LEN_C) begin
                move_s     = 1'b1;
                filt_nxt_s = 4'd0;
            end else begin
                move_s     = 1'b0;
                filt_nxt_s = filt_inc_s;
            end
        end else begin
            move_s     = 1'b0;
            filt_nxt_s = 4'd0;
        end
        if (move_s && later_s) begin
            phase_nxt_s = p_up_s;
        end else if (move_s) begin
            phase_nxt_s = p_dn_s;
        end else begin
            phase_nxt_s = phase_r;
        end
        // A wrap gains or loses one UI inside this window
        if (move_s && earlier_s && (phase_r == 2'd0)) begin
            raw_bits_s  = {w_r[7], w_r[4], w_r[0]};
            raw_nbits_s = 2'd3;
        end else if (move_s && later_s && (phase_r == 2'd3)) begin
            raw_bits_s  = {2'b00, w_r[3]};
            raw_nbits_s = 2'd1;
        end else begin
            raw_bits_s  = {1'b0, w_r[{1'b1, phase_nxt_s}], w_r[{1'b0, phase_nxt_s}]};
            raw_nbits_s = 2'd2;
        end
    end

    // Stage 2: phase, filter, recovered bits and lock tracking
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            phase_r     <= 2'd1;
            filt_cnt_r  <= 4'd0;
            last_dir_r  <= 1'b0;
            raw_bits_r  <= 3'b000;
            raw_nbits_r <= 2'd0;
            lock_cnt_r  <= 16'd0;
            locked_r    <= 1'b0;
        end else if (v1_r) begin
            phase_r     <= phase_nxt_s;
            filt_cnt_r  <= filt_nxt_s;
            last_dir_r  <= later_s;
            raw_bits_r  <= raw_bits_s;
            raw_nbits_r <= raw_nbits_s;
            if (move_s) begin
                lock_cnt_r <= 16'd0;
                locked_r   <= 1'b0;
            end else if (lock_cnt_r != LOCK_MAX_C) begin
                lock_cnt_r <= lock_cnt_r + 16'd1;
                locked_r   <= ((lock_cnt_r + 16'd1) == LOCK_MAX_C);
            end else begin
                locked_r   <= 1'b1;
            end
        end
    end

`ifdef DRU_BITSLIP_EN
    logic slip_pend_r;

    assign slip_take_s = slip_pend_r && (raw_nbits_r != 2'd0);

    // Slip request held until the next recovered bits reach the gearbox
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            slip_pend_r <= 1'b0;
        end else if (slip_pend_r) begin
            slip_pend_r <= !slip_take_s;
        end else begin
            slip_pend_r <= bitslip;
        end
    end
`else
    logic unused_bitslip_s;

    assign unused_bitslip_s = bitslip;
    assign slip_take_s      = 1'b0;
`endif

    // Gearbox merge: new bits land directly above the bits already held
    always_comb begin
        if (slip_take_s) begin
            app_bits_s = {1'b0, raw_bits_r[2:1]};
            app_n_s    = raw_nbits_r - 2'd1;
        end else begin
            app_bits_s = raw_bits_r;
            app_n_s    = raw_nbits_r;
        end
        merged_s = acc_r | (ACC_W'(app_bits_s) << gb_cnt_r);
        total_s  = gb_cnt_r + CNT_W'(app_n_s);
        emit_s   = (total_s >= OUT_W_C);
    end

    // Stage 3: emit a full word and keep the remainder
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            acc_r      <= '0;
            gb_cnt_r   <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
        end else if (emit_s) begin
            rx_data_r  <= merged_s[OUT_W-1:0];
            rx_valid_r <= 1'b1;
            acc_r      <= merged_s >> OUT_W;
            gb_cnt_r   <= total_s - OUT_W_C;
        end else begin
            rx_valid_r <= 1'b0;
            acc_r      <= merged_s;
            gb_cnt_r   <= total_s;
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign raw_bits  = raw_bits_r;
    assign raw_nbits = raw_nbits_r;
    assign phase     = phase_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_dru_gearbox_lane.sv
// Directed self-checking bench for dru_gearbox_lane (OUT_W=10, LOCK_CNT=16; FILTER_LEN 1 and 3).
module tb_dru_gearbox_lane;
    logic       clk = 1'b0;
    logic       aresetn;
    logic       bitslip;
    logic [7:0] sample_window;

    logic [9:0] rx_data;
    logic       rx_valid;
    logic [2:0] raw_bits;
    logic [1:0] raw_nbits;
    logic [1:0] phase;
    logic       locked;

    logic [9:0] f3_rx_data_unused;
    logic       f3_rx_valid_unused;
    logic [2:0] f3_raw_bits_unused;
    logic [1:0] f3_raw_nbits_unused;
    logic [1:0] phase_f3;
    logic       f3_locked_unused;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dru_gearbox_lane #(.OUT_W(10), .FILTER_LEN(1), .LOCK_CNT(16)) dut (
        .clk(clk), .aresetn(aresetn), .sample_window(sample_window), .bitslip(bitslip),
        .rx_data(rx_data), .rx_valid(rx_valid), .raw_bits(raw_bits), .raw_nbits(raw_nbits),
        .phase(phase), .locked(locked)
    );

    dru_gearbox_lane #(.OUT_W(10), .FILTER_LEN(3), .LOCK_CNT(16)) dut_f3 (
        .clk(clk), .aresetn(aresetn), .sample_window(sample_window), .bitslip(bitslip),
        .rx_data(f3_rx_data_unused), .rx_valid(f3_rx_valid_unused), .raw_bits(f3_raw_bits_unused),
        .raw_nbits(f3_raw_nbits_unused), .phase(phase_f3), .locked(f3_locked_unused)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this, the next tick captures window w as the first post-reset window
    task automatic do_reset(input logic [7:0] w);
        aresetn       = 1'b0;
        bitslip       = 1'b0;
        sample_window = w;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bitslip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_window = 8'($urandom);
            tick();
            checks++;
            if (rx_data !== 10'h000 || rx_valid !== 1'b0 || raw_bits !== 3'b000 ||
                raw_nbits !== 2'd0 || phase !== 2'd1 || locked !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: data=%h v=%b bits=%b n=%0d ph=%0d lk=%b, want 0/0/0/0/1/0",
                         i, rx_data, rx_valid, raw_bits, raw_nbits, phase, locked);
            end
        end
        aresetn       = 1'b1;
        sample_window = 8'h0F;
        tick();
        checks++;
        if (raw_nbits !== 2'd0) begin
            errors++;
            $display("FAIL release_e1: raw_nbits=%0d want 0", raw_nbits);
        end
        tick();
        checks++;
        if (raw_nbits !== 2'd2) begin
            errors++;
            $display("FAIL release_e2: raw_nbits=%0d want 2", raw_nbits);
        end
    endtask

    task automatic test_pattern_0f();
        logic exp_v;
        do_reset(8'h0F);
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e >= 2) begin
                checks++;
                if (phase !== 2'd2 || raw_bits[1:0] !== 2'b01 || raw_nbits !== 2'd2) begin
                    errors++;
                    $display("FAIL p0f_raw e%0d: ph=%0d bits=%b n=%0d want ph=2 bits=x01 n=2",
                             e, phase, raw_bits, raw_nbits);
                end
            end
            if (e >= 3) begin
                exp_v = (e == 7 || e == 12 || e == 17);
                checks++;
                if (rx_valid !== exp_v || (exp_v && rx_data !== 10'h155)) begin
                    errors++;
                    $display("FAIL p0f_word e%0d: v=%b data=%h want v=%b data=155", e, rx_valid, rx_data, exp_v);
                end
            end
        end
    endtask

    task automatic test_drift_later();
        int n1 = 0;
        int bits = 0;
        do_reset(8'h1E);
        for (int e = 1; e <= 40; e++) begin
            if (e == 20) sample_window = 8'h3C;
            tick();
            if (raw_nbits == 2'd1) n1++;
            bits += int'(raw_nbits);
            if (e == 19) begin
                checks++;
                if (phase !== 2'd3) begin
                    errors++;
                    $display("FAIL later_pre_phase: phase=%0d want 3", phase);
                end
            end
            if (e == 21) begin
                checks++;
                if (raw_nbits !== 2'd1 || raw_bits !== 3'b001 || phase !== 2'd0) begin
                    errors++;
                    $display("FAIL later_wrap: n=%0d bits=%b ph=%0d want n=1 bits=001 ph=0", raw_nbits, raw_bits, phase);
                end
            end
            if (rx_valid === 1'b1) begin
                checks++;
                if (rx_data !== 10'h155) begin
                    errors++;
                    $display("FAIL later_word e%0d: data=%h want 155", e, rx_data);
                end
            end
        end
        checks++;
        if (n1 != 1 || bits != 77 || phase !== 2'd0) begin
            errors++;
            $display("FAIL later_totals: n1=%0d bits=%0d ph=%0d want 1/77/0", n1, bits, phase);
        end
    endtask

    task automatic test_drift_earlier();
        int n3 = 0;
        int bits = 0;
        do_reset(8'h3C);
        for (int e = 1; e <= 40; e++) begin
            if (e == 20) sample_window = 8'h1E;
            tick();
            if (raw_nbits == 2'd3) n3++;
            bits += int'(raw_nbits);
            if (e == 19) begin
                checks++;
                if (phase !== 2'd0) begin
                    errors++;
                    $display("FAIL earlier_pre_phase: phase=%0d want 0", phase);
                end
            end
            if (e == 21) begin
                checks++;
                if (raw_nbits !== 2'd3 || raw_bits !== 3'b010 || phase !== 2'd3) begin
                    errors++;
                    $display("FAIL earlier_wrap: n=%0d bits=%b ph=%0d want n=3 bits=010 ph=3", raw_nbits, raw_bits, phase);
                end
            end
            if (rx_valid === 1'b1) begin
                checks++;
                if (rx_data !== 10'h2AA) begin
                    errors++;
                    $display("FAIL earlier_word e%0d: data=%h want 2aa", e, rx_data);
                end
            end
        end
        checks++;
        if (n3 != 1 || bits != 79 || phase !== 2'd3) begin
            errors++;
            $display("FAIL earlier_totals: n3=%0d bits=%0d ph=%0d want 1/79/3", n3, bits, phase);
        end
    endtask

    task automatic test_lock();
        do_reset(8'h0F);
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e >= 2) begin
                checks++;
                if (locked !== (e == 18) || phase !== 2'd2) begin
                    errors++;
                    $display("FAIL lock_rise e%0d: locked=%b ph=%0d want locked=%b ph=2", e, locked, phase, (e == 18));
                end
            end
        end
        sample_window = 8'h1E;
        tick();
        checks++;
        if (locked !== 1'b1 || phase !== 2'd2) begin
            errors++;
            $display("FAIL lock_hold: locked=%b ph=%0d want 1/2", locked, phase);
        end
        tick();
        checks++;
        if (locked !== 1'b0 || phase !== 2'd3) begin
            errors++;
            $display("FAIL lock_drop: locked=%b ph=%0d want 0/3", locked, phase);
        end
    endtask

    task automatic test_filter();
        do_reset(8'h0F);
        for (int e = 1; e <= 14; e++) begin
            if (e <= 10) sample_window = (e % 2 == 1) ? 8'h0F : 8'h3C;
            else sample_window = 8'h0F;
            tick();
            if (e >= 2) begin
                checks++;
                if (phase_f3 !== ((e == 14) ? 2'd2 : 2'd1)) begin
                    errors++;
                    $display("FAIL filter3 e%0d: phase=%0d want %0d", e, phase_f3, (e == 14) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_bitslip();
        logic       exp_v;
        logic [9:0] exp_d;
        do_reset(8'h0F);
        for (int e = 1; e <= 23; e++) begin
            if (e == 10) bitslip = 1'b1;
            if (e == 11) bitslip = 1'b0;
            tick();
`ifdef DRU_BITSLIP_EN
            exp_v = (e == 7 || e == 13 || e == 18 || e == 23);
            exp_d = (e == 7) ? 10'h155 : ((e == 13) ? 10'h295 : 10'h2AA);
`else
            exp_v = (e == 7 || e == 12 || e == 17 || e == 22);
            exp_d = 10'h155;
`endif
            if (e >= 3) begin
                checks++;
                if (rx_valid !== exp_v || (exp_v && rx_data !== exp_d)) begin
                    errors++;
                    $display("FAIL bitslip e%0d: v=%b data=%h want v=%b data=%h", e, rx_valid, rx_data, exp_v, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        do_reset(8'h0F);
        for (int e = 1; e <= 9; e++) tick();
        aresetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rx_valid !== 1'b0 || raw_nbits !== 2'd0 || phase !== 2'd1) begin
                errors++;
                $display("FAIL midreset_hold: v=%b n=%0d ph=%0d want 0/0/1", rx_valid, raw_nbits, phase);
            end
        end
        aresetn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_v = (e == 7 || e == 12);
            checks++;
            if (rx_valid !== exp_v || (exp_v && rx_data !== 10'h155)) begin
                errors++;
                $display("FAIL midreset_word e%0d: v=%b data=%h want v=%b data=155", e, rx_valid, rx_data, exp_v);
            end
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        bitslip       = 1'b0;
        sample_window = 8'h00;
        test_reset();
        test_pattern_0f();
        test_drift_later();
        test_drift_earlier();
        test_lock();
        test_filter();
        test_bitslip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
